data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory.sv | 99 +++++++++
 tb/tb_data_memory.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Word-addressed data memory with a fixed-latency MFC handshake.
// A request is latched in IDLE, performed after LATENCY cycles, and held in DONE until memEN drops.
module data_memory #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memEN,
  input  logic              RW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              MFC,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_rw;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_fire;
  logic w_mem_we;

  // The access fires on the edge that leaves WAIT with an exhausted counter.
  assign w_fire   = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_mem_we = w_fire && !r_rw;

  // Control FSM with registered handshake and read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_rw    <= 1'b0;
      MFC     <= 1'b0;
      busy    <= 1'b0;
      dataOut <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (memEN) begin
            r_addr  <= addr;
            r_data  <= dataIn;
            r_rw    <= RW;
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_state <= S_WAIT;
            busy    <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state <= S_DONE;
            MFC     <= 1'b1;
            if (r_rw) begin
              dataOut <= r_mem[r_addr];
            end
          end
        end
        S_DONE: begin
          if (!memEN) begin
            r_state <= S_IDLE;
            MFC     <= 1'b0;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          MFC     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= r_data;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: LATENCY=3 and LATENCY=1 instances share clock, reset and request buses,
// each with its own memEN, checked against an array model of storage and handshake timing.
module tb_data_memory;

  logic        clk;
  logic        rst;
  logic        men0, men1;
  logic        RW;
  logic [7:0]  addr;
  logic [15:0] dataIn;
  logic [15:0] dout0, dout1;
  logic        mfc0, mfc1, busy0, busy1;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] m_mem   [2][256];
  bit          m_valid [2][256];
  logic [15:0] m_dout  [2];
  bit          m_dknown[2];

  data_memory #(.ADDR_W(8), .DATA_W(16), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .memEN(men0), .RW(RW), .addr(addr), .dataIn(dataIn),
    .dataOut(dout0), .MFC(mfc0), .busy(busy0)
  );

  data_memory #(.ADDR_W(8), .DATA_W(16), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .memEN(men1), .RW(RW), .addr(addr), .dataIn(dataIn),
    .dataOut(dout1), .MFC(mfc1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic mfc_of(input int inst);
    return (inst == 0) ? mfc0 : mfc1;
  endfunction

  function automatic logic busy_of(input int inst);
    return (inst == 0) ? busy0 : busy1;
  endfunction

  function automatic logic [15:0] dout_of(input int inst);
    return (inst == 0) ? dout0 : dout1;
  endfunction

  task automatic set_en(input int inst, input logic v);
    if (inst == 0) men0 = v;
    else men1 = v;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete access: accept, MFC after exactly LATENCY edges, then either a held
  // 4-phase release or an early drop during WAIT. Request buses are scrambled after accept.
  task automatic access(input int inst, input bit rw, input logic [7:0] a, input logic [15:0] d,
                        input int hold, input bit early);
    int lat;
    lat = (inst == 0) ? 3 : 1;
    RW = rw; addr = a; dataIn = d;
    set_en(inst, 1'b1);
    tick();
    check_eq("busy_accept", busy_of(inst), 1);
    check_eq("mfc_accept", mfc_of(inst), 0);
    RW = ~rw; addr = a ^ 8'h30; dataIn = ~d;
    for (int k = 1; k <= lat; k++) begin
      if (early && k == 1) set_en(inst, 1'b0);
      tick();
      check_eq("mfc_latency", mfc_of(inst), (k == lat) ? 1 : 0);
    end
    check_eq("busy_done", busy_of(inst), 1);
    if (rw) begin
      if (m_valid[inst][a]) begin
        check_eq("read_data", dout_of(inst), m_mem[inst][a]);
        m_dout[inst]   = m_mem[inst][a];
        m_dknown[inst] = 1'b1;
      end else begin
        m_dknown[inst] = 1'b0;
      end
    end else begin
      m_mem[inst][a]   = d;
      m_valid[inst][a] = 1'b1;
      if (m_dknown[inst]) check_eq("write_keeps_dout", dout_of(inst), m_dout[inst]);
    end
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        tick();
        check_eq("mfc_hold", mfc_of(inst), 1);
        check_eq("busy_hold", busy_of(inst), 1);
      end
      set_en(inst, 1'b0);
    end
    tick();
    check_eq("mfc_release", mfc_of(inst), 0);
    check_eq("busy_release", busy_of(inst), 0);
    if (m_dknown[inst]) check_eq("dout_stable", dout_of(inst), m_dout[inst]);
  endtask

  initial begin
    logic [7:0] ra;
    int         sel;
    rst = 1'b0; men0 = 1'b0; men1 = 1'b0; RW = 1'b0; addr = '0; dataIn = '0;
    for (int i = 0; i < 2; i++) begin
      m_dout[i] = '0;
      m_dknown[i] = 1'b1;
      for (int j = 0; j < 256; j++) m_valid[i][j] = 1'b0;
    end
    tick();
    tick();
    check_eq("rst_mfc0", mfc0, 0);
    check_eq("rst_busy0", busy0, 0);
    check_eq("rst_dout0", dout0, 0);
    check_eq("rst_dout1", dout1, 0);
    rst = 1'b1;

    // Write then read back, held handshake, input isolation, early release.
    access(0, 1'b0, 8'h42, 16'hA5C3, 0, 1'b0);
    access(0, 1'b1, 8'h42, 16'h0000, 0, 1'b0);
    access(0, 1'b1, 8'h42, 16'h0000, 5, 1'b0);
    access(0, 1'b0, 8'h10, 16'h1111, 0, 1'b0);
    access(0, 1'b0, 8'h20, 16'h2222, 0, 1'b0);
    access(0, 1'b1, 8'h10, 16'h0000, 1, 1'b0);
    access(0, 1'b0, 8'h05, 16'hBEEF, 0, 1'b1);
    access(0, 1'b1, 8'h05, 16'h0000, 0, 1'b0);

    // Reset while a write is in flight must leave storage untouched.
    access(0, 1'b0, 8'h07, 16'h0001, 0, 1'b0);
    RW = 1'b0; addr = 8'h07; dataIn = 16'hFFFF; men0 = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("rstwait_mfc", mfc0, 0);
    check_eq("rstwait_busy", busy0, 0);
    check_eq("rstwait_dout0", dout0, 0);
    check_eq("rstwait_dout1", dout1, 0);
    m_dout[0] = '0; m_dout[1] = '0; m_dknown[0] = 1'b1; m_dknown[1] = 1'b1;
    men0 = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    access(0, 1'b1, 8'h07, 16'h0000, 0, 1'b0);

    // Single-cycle latency at the top address.
    access(1, 1'b0, 8'hFF, 16'h7E7E, 0, 1'b0);
    access(1, 1'b1, 8'hFF, 16'h0000, 2, 1'b0);

    // Randomized traffic on both instances over a small address pool to get read hits.
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      ra = (sel == 8) ? 8'hFF : (sel == 9) ? 8'h80 : 8'(sel);
      access(n % 2, 1'($urandom_range(0, 1)), ra, 16'($urandom), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
